lsu_data_mem: RTL and testbench

Parametrised, byte-addressed data memory with a load/store front end; next generation of the core's word-indexed data memory. Supports byte/half/word accesses with sign or zero extension, alignment and range checking, and configurable read latency behind a valid/ready request and one-cycle response pulse. Sits between the ALU address result and the write-back mux; the control unit holds the pipeline while req_ready is low.

---
 rtl/lsu_data_mem.sv | 155 +++++++++++++++
 tb/tb_lsu_data_mem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_mem.sv
// Byte-addressed data memory with a load/store front end: byte/half/word
// accesses, alignment and range checks, and a configurable load latency.
module lsu_data_mem #(
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];
    logic [1:0]    cnt;
    logic          we_q, err_q, uns_q;
    logic [1:0]    size_q, lane_q;
    logic [AW-1:0] idx_q;

    logic          accept, respond, req_err, misaligned, out_of_range;
    logic [AW-1:0] req_idx;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes, lane_mask;
    logic [31:0]   rd_word, load_data;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    assign req_ready    = (state == IDLE) && reset;
    assign busy         = (state == WAIT);
    assign accept       = req_valid && req_ready;
    assign respond      = (state == WAIT) && (cnt == '0);
    assign req_idx      = req_addr[AW+1:2];
    assign out_of_range = |req_addr[31:AW+2];

    always_comb begin
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign req_err = (req_size == 2'b11) || misaligned || out_of_range;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = '0;
        case (req_size)
            2'b00: begin
                byte_en     = 4'b0001 << req_addr[1:0];
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en     = 4'b1111;
                wdata_lanes = req_wdata;
            end
            default: ;
        endcase
    end

    assign lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)  state_nxt = WAIT;
            WAIT: if (respond) state_nxt = IDLE;
        endcase
    end

    // Stores and errors answer on the next edge; clean loads wait RD_LAT edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= '0;
            lane_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            cnt    <= (req_we || req_err) ? 2'd0 : 2'(RD_LAT - 1);
            we_q   <= req_we;
            err_q  <= req_err;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            lane_q <= req_addr[1:0];
            idx_q  <= req_idx;
        end else if (busy && cnt != '0) begin
            cnt <= cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
        end else if (accept && req_we && !req_err) begin
            mem[req_idx] <= (mem[req_idx] & ~lane_mask) | (wdata_lanes & lane_mask);
        end
    end

    assign rd_word = mem[idx_q];
    assign rd_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= respond;
            if (respond) begin
                resp_err   <= err_q;
                resp_rdata <= (we_q || err_q) ? '0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench for lsu_data_mem: vector table on an RD_LAT=1 instance,
// plus latency/back-to-back and reset-abort sequences.
module tb_lsu_data_mem;
    logic        clk, reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        v3, rdy3, we3, uns3, rv3, err3, busy3;
    logic [1:0]  sz3;
    logic [31:0] a3, wd3, rd3;

    int checks = 0;
    int errors = 0;

    lsu_data_mem #(.DEPTH(64), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    lsu_data_mem #(.DEPTH(64), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3),
        .req_we(we3), .req_size(sz3), .req_unsigned(uns3),
        .req_addr(a3), .req_wdata(wd3), .resp_valid(rv3),
        .resp_rdata(rd3), .resp_err(err3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic rdy, output logic vnext, output logic [31:0] rdnext);
        @(negedge clk);
        req_valid = 1'b1; req_we = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid && lat < 10);
        rd  = resp_rdata;
        er  = resp_err;
        rdy = req_ready;
        @(posedge clk); #1;
        vnext  = resp_valid;
        rdnext = resp_rdata;
    endtask

    logic [31:0] rd, rdn;
    logic        er, rdy, vn;
    int          lat, seen;

    initial begin
        //              we    sz     u     addr          wdata         exp_rd        err
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h8081_F0F7, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_FFF7, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_00F7, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_8081, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_8081, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h1234_56AA, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h8081_AAF7, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0023, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h0000_0024, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0,         32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hABCD_1234, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_AAF7, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'h0,         32'h0000_0012, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_0034, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_AAF7, 1'b0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0026, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0027, 32'h0000_00FF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0027, 32'h0,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0026, 32'h0,         32'h0000_FF00, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0026, 32'h0,         32'hFFFF_FF00, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_00FC, 32'h1122_3344, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_00FF, 32'h0,         32'h0000_0011, 1'b0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0,         32'h1122_3344, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1});

        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        v3 = 1'b0; we3 = 1'b0; sz3 = 2'b10; uns3 = 1'b0; a3 = 32'h0000_0010; wd3 = '0;

        #1;
        chk1("reset_ready_low", req_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("reset_ready", req_ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_resp_valid", resp_valid, 1'b0);
        chk1("reset_resp_err", resp_err, 1'b0);
        chk32("reset_resp_rdata", resp_rdata, 32'h0);

        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, er, lat, rdy, vn, rdn);
            chk32($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk1($sformatf("v%0d_err", i), er, vecs[i].exp_err);
            chk32($sformatf("v%0d_latency", i), lat, 32'd1);
            chk1($sformatf("v%0d_ready_at_resp", i), rdy, 1'b1);
            chk1($sformatf("v%0d_pulse_one_cycle", i), vn, 1'b0);
            chk32($sformatf("v%0d_rdata_hold", i), rdn, vecs[i].exp_rd);
        end

        // RD_LAT=3 latency and back-to-back acceptance with request held valid
        @(negedge clk);
        v3 = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            chk1($sformatf("lat3_busy_c%0d", c), busy3, 1'b1);
            chk1($sformatf("lat3_ready_c%0d", c), rdy3, 1'b0);
            chk1($sformatf("lat3_noresp_c%0d", c), rv3, 1'b0);
            @(posedge clk); #1;
        end
        chk1("lat3_resp_valid", rv3, 1'b1);
        chk1("lat3_resp_ready", rdy3, 1'b1);
        chk1("lat3_resp_busy", busy3, 1'b0);
        chk1("lat3_resp_err", err3, 1'b0);
        chk32("lat3_resp_rdata", rd3, 32'h0);
        @(posedge clk); #1;
        chk1("lat3_second_accepted", busy3, 1'b1);
        chk1("lat3_pulse_ended", rv3, 1'b0);
        v3 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rv3 && lat < 10);
        chk32("lat3_second_latency", lat, 32'd3);

        // Reset while a load is in WAIT must abort it with no response
        txn(1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hCAFE_BABE, rd, er, lat, rdy, vn, rdn);
        txn(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, rd, er, lat, rdy, vn, rdn);
        chk32("abort_pre_load", rd, 32'hCAFE_BABE);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0030;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk1("abort_in_wait", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk1("abort_busy_cleared", busy, 1'b0);
        chk1("abort_ready_in_reset", req_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk32("abort_no_response", seen, 32'd0);
        txn(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, rd, er, lat, rdy, vn, rdn);
        chk32("abort_mem_cleared_30", rd, 32'h0);
        chk1("abort_load_err", er, 1'b0);
        txn(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, rd, er, lat, rdy, vn, rdn);
        chk32("abort_mem_cleared_20", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
